// File: rtl/param_seq_det.sv
// rtl/param_seq_det.sv - parametrised serial pattern detector with one-cycle grant pulse
//
// Samples req whenever en is high and compares the last SEQ_LEN sampled bits
// (oldest bit in the MSB) against a runtime-loadable pattern. A match raises
// gnt for one cycle, registered, and bumps a saturating match counter.
// Optional build macro: SEQ_DET_MASK_EN adds a per-bit don't-care mask.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous active-low reset
//   en        in   sample strobe; req is consumed only when en is high
//   req       in   serial request bit
//   overlap   in   1 = overlapping detection, 0 = restart fill after a match
//   cfg_load  in   load cfg_seq (and cfg_mask) as the new pattern, flush history
//   cfg_seq   in   new pattern, MSB = oldest bit
//   cfg_mask  in   (SEQ_DET_MASK_EN only) 1 = pattern bit is don't-care
//   cnt_clr   in   synchronous clear of match_cnt, wins over a same-cycle match
//   gnt       out  one-cycle match pulse, visible the cycle after the sample
//   match_cnt out  saturating match count
//   armed     out  detector holds SEQ_LEN-1 valid history bits

module param_seq_det #(
  parameter int                 SEQ_LEN = 3,
  parameter int                 CNT_W   = 8,
  parameter logic [SEQ_LEN-1:0] RST_SEQ = SEQ_LEN'(3'b110)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               req,
  input  logic               overlap,
  input  logic               cfg_load,
  input  logic [SEQ_LEN-1:0] cfg_seq,
`ifdef SEQ_DET_MASK_EN
  input  logic [SEQ_LEN-1:0] cfg_mask,
`endif
  input  logic               cnt_clr,
  output logic               gnt,
  output logic [CNT_W-1:0]   match_cnt,
  output logic               armed
);

  localparam int                FILL_W    = $clog2(SEQ_LEN);
  localparam logic [FILL_W-1:0] FILL_TOP  = FILL_W'(SEQ_LEN - 1);
  // fill value seen on the sample that completes the history
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(SEQ_LEN - 2);

  typedef enum logic {
    S_FILL  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t               state_q, state_d;
  logic [SEQ_LEN-1:0]   pattern_q, pattern_d;
  logic [SEQ_LEN-2:0]   hist_q, hist_d;
  logic [FILL_W-1:0]    fill_q, fill_d;
  logic                 gnt_q, gnt_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [SEQ_LEN-1:0]   cand;
  logic                 hit;
  logic                 match;

  // candidate word: stored history with the current req appended as newest bit
  assign cand = {hist_q, req};

`ifdef SEQ_DET_MASK_EN
  logic [SEQ_LEN-1:0] mask_q, mask_d;
  assign hit = ((cand ^ pattern_q) & ~mask_q) == '0;
`else
  assign hit = (cand == pattern_q);
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FILL;
      pattern_q <= RST_SEQ;
      hist_q    <= '0;
      fill_q    <= '0;
      gnt_q     <= 1'b0;
      cnt_q     <= '0;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      hist_q    <= hist_d;
      fill_q    <= fill_d;
      gnt_q     <= gnt_d;
      cnt_q     <= cnt_d;
`ifdef SEQ_DET_MASK_EN
      mask_q    <= mask_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    hist_d    = hist_q;
    fill_d    = fill_q;
    match     = 1'b0;
`ifdef SEQ_DET_MASK_EN
    mask_d    = mask_q;
`endif

    if (cfg_load) begin
      // reload drops the same-cycle sample entirely; nothing is compared
      pattern_d = cfg_seq;
`ifdef SEQ_DET_MASK_EN
      mask_d    = cfg_mask;
`endif
      hist_d    = '0;
      fill_d    = '0;
      state_d   = S_FILL;
    end else if (en) begin
      hist_d = cand[SEQ_LEN-2:0];
      unique case (state_q)
        S_FILL: begin
          if (fill_q == FILL_LAST) begin
            fill_d  = FILL_TOP;
            state_d = S_ARMED;
          end else begin
            fill_d = fill_q + FILL_W'(1);
          end
        end
        S_ARMED: begin
          if (hit) begin
            match = 1'b1;
            // non-overlapping: stale history stays but is ignored until refilled
            if (!overlap) begin
              fill_d  = '0;
              state_d = S_FILL;
            end
          end
        end
        default: state_d = S_FILL;
      endcase
    end

    gnt_d = match;

    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (match && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign gnt       = gnt_q;
  assign match_cnt = cnt_q;
  assign armed     = (state_q == S_ARMED);

endmodule
